seq_bin2bcd: RTL

// - Parametrised, multi-cycle binary-to-BCD converter (shift-and-add-3 / double dabble), one bit per clock.
// - Next generation of the combinational 16-bit converter: generic width/digit count, start/busy/done handshake,

---
 rtl/seq_bin2bcd_if.sv | 45 ++++
 rtl/seq_bin2bcd.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_bin2bcd_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_bin2bcd_if                                             |
// | Description : Handshake and result bundle for the sequential binary to   |
// |               BCD converter. master = requester/display side, slave =    |
// |               converter.                                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface seq_bin2bcd_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);

   logic                  start;
   logic [BIN_W-1:0]      bin_in;
   logic                  enable;
   logic                  busy;
   logic                  done;
   logic                  overflow;
   logic [4*DIGITS-1:0]   bcd_out;

   // Requester drives the operand and display enable, observes the result.
   modport master (
      output start,
      output bin_in,
      output enable,
      input  busy,
      input  done,
      input  overflow,
      input  bcd_out
   );

   // Converter side.
   modport slave (
      input  start,
      input  bin_in,
      input  enable,
      output busy,
      output done,
      output overflow,
      output bcd_out
   );

endinterface : seq_bin2bcd_if
`default_nettype wire

// File: rtl/seq_bin2bcd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seq_bin2bcd                                                |
// | Description : Multi-cycle binary to BCD converter (double dabble), one   |
// |               operand bit per clock. Registered result with overflow,    |
// |               optional leading-zero blanking and display blanking.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seq_bin2bcd #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter bit LZB    = 1'b0
) (
   input  logic          clk,
   input  logic          rst_n,
   seq_bin2bcd_if.slave  bus
);

   localparam int               BCD_W    = 4 * DIGITS;
   localparam int               CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nx;

   // Control strobes decoded by the FSM
   logic               load;      // accept operand this edge
   logic               step;      // perform one add-3/shift step this edge
   logic               finish;    // last step: capture result this edge

   // Conversion datapath
   logic [BIN_W-1:0]   shift_reg;
   logic [BCD_W-1:0]   scratch;
   logic [CNT_W-1:0]   count;
   logic               ovf_tmp;

   logic [BCD_W-1:0]   scratch_adj;
   logic [BCD_W-1:0]   scratch_nx;
   logic [BIN_W-1:0]   shift_nx;
   logic               carry_out;
   logic               ovf_nx;

   // Held result, only updated on DONE entry
   logic [BCD_W-1:0]   result;
   logic               overflow_reg;

   // Display path
   logic [BCD_W-1:0]   display;
   logic               seen_nz;

   // ------------------------------------------------------------------------
   // Add-3 correction: any scratch digit >= 5 would carry after doubling
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         assign scratch_adj[4*k +: 4] = (scratch[4*k +: 4] >= 4'd5)
                                      ? scratch[4*k +: 4] + 4'd3
                                      : scratch[4*k +: 4];
      end
   endgenerate

   // The concatenated {scratch, shift} register shifts left by one. The bit
   // leaving the top digit is a carry past 10^DIGITS, so it feeds overflow;
   // what stays in the digits is therefore the value mod 10^DIGITS.
   assign scratch_nx = {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
   assign shift_nx   = shift_reg << 1;
   assign carry_out  = scratch_adj[BCD_W-1];
   assign ovf_nx     = ovf_tmp | carry_out;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and control/handshake outputs
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = CONV;
            end
         end
         CONV: begin
            bus.busy = 1'b1;
            step     = 1'b1;
            if (count == LAST_CNT) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            bus.done = 1'b1;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Conversion working registers: load on start, one step per CONV cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         scratch   <= '0;
         count     <= '0;
         ovf_tmp   <= 1'b0;
      end else if (load) begin
         shift_reg <= bus.bin_in;
         scratch   <= '0;
         count     <= '0;
         ovf_tmp   <= 1'b0;
      end else if (step) begin
         shift_reg <= shift_nx;
         scratch   <= scratch_nx;
         count     <= count + CNT_W'(1);
         ovf_tmp   <= ovf_nx;
      end
   end

   // Result capture on the final step, so a reset mid-conversion never
   // exposes a partial value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result       <= '0;
         overflow_reg <= 1'b0;
      end else if (finish) begin
         result       <= scratch_nx;
         overflow_reg <= ovf_nx;
      end
   end

   // Display formatting: leading-zero blanking from the top down, digit 0 is
   // always shown; display disable overrides everything with the blank code
   always_comb begin
      display = result;
      seen_nz = 1'b0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         if (result[4*k +: 4] != 4'd0) begin
            seen_nz = 1'b1;
         end
         if (LZB && !seen_nz) begin
            display[4*k +: 4] = 4'hF;
         end
      end
      if (!bus.enable) begin
         display = '1;
      end
   end

   assign bus.bcd_out  = display;
   assign bus.overflow = overflow_reg;

endmodule : seq_bin2bcd
`default_nettype wire
